// File: rtl/ascon_out_collector.sv
// Collects the Ascon core's unstallable 32-bit output stream into 64-bit blocks behind a small FIFO,
// and gathers the four tag words into a single 128-bit tag held for a valid/ready host.
module ascon_out_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic [3:0]   in_type,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [31:0]  in_tag,
  input  logic         in_tag_valid,
  output logic [63:0]  out_block,
  output logic [1:0]   out_keep,
  output logic [3:0]   out_type,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] tag_out,
  output logic         tag_out_valid,
  input  logic         tag_out_ready,
  output logic [1:0]   overflow
);

  typedef struct packed {
    logic [63:0] blk;
    logic [1:0]  keep;
    logic [3:0]  typ;
    logic        last;
  } ent_t;

  typedef enum logic {HALF_EMPTY, HALF_FULL} half_e;

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  half_e       state, state_nxt;
  logic [31:0] st_data;
  logic [3:0]  st_type;
  logic        ld_store;

  ent_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic [AW:0]   cnt;

  ent_t        p0, p1;
  logic        v0, v1, acc;
  logic        pop, acc0, acc1, blk_drop;
  logic [1:0]  n_push;
  logic [AW+1:0] free;

  // Pair register: up to two pushes per cycle (flushed half plus a lone last word).
  always_comb begin
    state_nxt = state;
    ld_store  = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    p0 = '0;
    p1 = '0;
    acc = in_valid && (in_type != 4'd0);
    if (acc) begin
      if (state == HALF_FULL && in_type == st_type) begin
        v0 = 1'b1;
        p0 = {st_data, in_data, 2'b11, st_type, in_last};
        state_nxt = HALF_EMPTY;
      end else begin
        if (state == HALF_FULL) begin
          v0 = 1'b1;
          p0 = {st_data, 32'h0, 2'b10, st_type, 1'b0};
        end
        if (in_last) begin
          if (state == HALF_FULL) begin
            v1 = 1'b1;
            p1 = {in_data, 32'h0, 2'b10, in_type, 1'b1};
          end else begin
            v0 = 1'b1;
            p0 = {in_data, 32'h0, 2'b10, in_type, 1'b1};
          end
          state_nxt = HALF_EMPTY;
        end else begin
          ld_store  = 1'b1;
          state_nxt = HALF_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HALF_EMPTY;
      st_data <= '0;
      st_type <= '0;
    end else begin
      state <= state_nxt;
      if (ld_store) begin
        st_data <= in_data;
        st_type <= in_type;
      end
    end
  end

  // A same-cycle pop frees a slot for the incoming push.
  assign pop      = out_valid && out_ready;
  assign free     = DEPTH_W - {1'b0, cnt} + {{(AW+1){1'b0}}, pop};
  assign acc0     = v0 && (free >= (AW+2)'(1));
  assign acc1     = v1 && (free >= (AW+2)'(2));
  assign blk_drop = (v0 && !acc0) || (v1 && !acc1);
  assign n_push   = {1'b0, acc0} + {1'b0, acc1};
  assign wr_ptr1  = wr_ptr + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (acc0) mem[wr_ptr]  <= p0;
      if (acc1) mem[wr_ptr1] <= p1;
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(n_push) - (AW+1)'(pop);
    end
  end

  assign {out_block, out_keep, out_type, out_last} = mem[rd_ptr];
  assign out_valid = (cnt != '0);

  logic [1:0]   tcnt;
  logic [127:0] tag_reg;
  logic         tag_vld, tag_take, tag_drop;

  assign tag_take = in_tag_valid && (!tag_vld || tag_out_ready);
  assign tag_drop = in_tag_valid && tag_vld && !tag_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt     <= '0;
      tag_reg  <= '0;
      tag_vld  <= 1'b0;
      overflow <= '0;
    end else begin
      if (tag_vld && tag_out_ready) tag_vld <= 1'b0;
      if (tag_take) begin
        case (tcnt)
          2'd0: tag_reg[127:96] <= in_tag;
          2'd1: tag_reg[95:64]  <= in_tag;
          2'd2: tag_reg[63:32]  <= in_tag;
          default: tag_reg[31:0] <= in_tag;
        endcase
        if (tcnt == 2'd3) tag_vld <= 1'b1;
        tcnt <= tcnt + 2'd1;
      end
      if (blk_drop) overflow[0] <= 1'b1;
      if (tag_drop) overflow[1] <= 1'b1;
    end
  end

  assign tag_out       = tag_reg;
  assign tag_out_valid = tag_vld;

endmodule
